risk_sequencer: RTL and testbench

Command sequencer for the RISK 4x4 tile engine. Accepts tile load, store and zero commands from the core over a valid/ready port and buffers them in a small FIFO. Drives the `risk` block's `risk_func`/`risk_reg`/`risk_addr`/`risk_stride_x`/`risk_stride_y` inputs, holding address and strides for as many cycles as the tile memory's two-stage address/data pipeline needs. One command is in flight at a time; zero commands issue back-to-back.

---
 rtl/risk_sequencer.sv | 132 +++++++++++++
 tb/tb_risk_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/risk_sequencer.sv
// Command sequencer for the RISK 4x4 tile engine: buffers load/store/zero commands in a
// small FIFO and drives the engine's function/register/address/stride inputs one command at a time.
module risk_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_REGS   = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [4:0]  cmd_reg,
   input  logic [16:0] cmd_addr,
   input  logic [14:0] cmd_stride_x,
   input  logic [14:0] cmd_stride_y,
   output logic [2:0]  risk_func,
   output logic [4:0]  risk_reg,
   output logic [16:0] risk_addr,
   output logic [14:0] risk_stride_x,
   output logic [14:0] risk_stride_y,
   output logic        busy,
   output logic        done,
   output logic        err
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [5:0] NREGS = 6'(NUM_REGS);

   localparam logic [2:0] FN_LOAD  = 3'b000;
   localparam logic [2:0] FN_STORE = 3'b001;
   localparam logic [2:0] FN_ZERO  = 3'b010;
   localparam logic [2:0] FN_IDLE  = 3'b111;

   typedef struct packed {
      logic [1:0]  op;
      logic [4:0]  rg;
      logic [16:0] addr;
      logic [14:0] sx;
      logic [14:0] sy;
   } cmd_t;

   typedef enum logic [2:0] {IDLE, LD_A, LD_B, LD_C, ST_A, ST_B} state_t;

   cmd_t            mem [FIFO_DEPTH];
   cmd_t            head;
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            push, pop, empty, bad;
   state_t          state, state_n;
   logic [2:0]      func_n;
   logic            done_n, err_n;

   assign empty     = (count == '0);
   assign cmd_ready = (count != CW'(FIFO_DEPTH));
   assign push      = cmd_valid & cmd_ready;
   assign head      = mem[rd_ptr];
   assign bad       = (head.op == 2'b11) || ({1'b0, head.rg} >= NREGS);
   assign busy      = !empty || (state != IDLE) || done;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{op: cmd_op, rg: cmd_reg, addr: cmd_addr,
                                 sx: cmd_stride_x, sy: cmd_stride_y};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Outputs are registered from the next state, so the last cycle of a command
   // (LD_C/ST_B, or an idle/zero cycle) is where the following pop is decided.
   always_comb begin
      state_n = state;
      pop     = 1'b0;
      func_n  = FN_IDLE;
      done_n  = 1'b0;
      err_n   = 1'b0;
      case (state)
         LD_A:    state_n = LD_B;
         LD_B:    begin state_n = LD_C; func_n = FN_LOAD; done_n = 1'b1; end
         ST_A:    begin state_n = ST_B; done_n = 1'b1; end
         default: state_n = IDLE;
      endcase
      if ((state == IDLE || state == LD_C || state == ST_B) && !empty) begin
         pop = 1'b1;
         if (bad) begin
            err_n = 1'b1;
         end else begin
            case (head.op)
               2'b00:   state_n = LD_A;
               2'b01:   begin state_n = ST_A; func_n = FN_STORE; end
               default: begin func_n = FN_ZERO; done_n = 1'b1; end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         risk_func     <= FN_IDLE;
         done          <= 1'b0;
         err           <= 1'b0;
         risk_reg      <= '0;
         risk_addr     <= '0;
         risk_stride_x <= '0;
         risk_stride_y <= '0;
      end else begin
         state     <= state_n;
         risk_func <= func_n;
         done      <= done_n;
         err       <= err_n;
         if (pop) begin
            risk_reg      <= head.rg;
            risk_addr     <= head.addr;
            risk_stride_x <= head.sx;
            risk_stride_y <= head.sy;
         end
      end
   end
endmodule

// File: tb/tb_risk_sequencer.sv
// Directed bench for risk_sequencer: hand-computed engine sequences checked with immediate assertions.
module tb_risk_sequencer;
   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_reg;
   logic [16:0] cmd_addr;
   logic [14:0] cmd_stride_x, cmd_stride_y;
   logic [2:0]  risk_func;
   logic [4:0]  risk_reg;
   logic [16:0] risk_addr;
   logic [14:0] risk_stride_x, risk_stride_y;
   logic        busy, done, err;

   int n_chk  = 0;
   int n_fail = 0;

   risk_sequencer #(.FIFO_DEPTH(4), .NUM_REGS(3)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
      .cmd_stride_x(cmd_stride_x), .cmd_stride_y(cmd_stride_y),
      .risk_func(risk_func), .risk_reg(risk_reg), .risk_addr(risk_addr),
      .risk_stride_x(risk_stride_x), .risk_stride_y(risk_stride_y),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] op, input logic [4:0] rg, input logic [16:0] a,
                        input logic [14:0] sx, input logic [14:0] sy);
      cmd_valid = 1'b1; cmd_op = op; cmd_reg = rg; cmd_addr = a;
      cmd_stride_x = sx; cmd_stride_y = sy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ndone;
      logic [2:0] ef;
      logic       ed;
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_reg = '0;
      cmd_addr = '0; cmd_stride_x = '0; cmd_stride_y = '0;
      #12;
      chk("rst_func", risk_func, 3'b111);
      chk("rst_reg", risk_reg, 0);
      chk("rst_addr", risk_addr, 0);
      chk("rst_sx", risk_stride_x, 0);
      chk("rst_sy", risk_stride_y, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      reset = 1'b0;
      tick();

      // Load reg 1, addr 0x00100, strides 1/4
      drive(2'b00, 5'd1, 17'h00100, 15'd1, 15'd4);
      tick(); cmd_valid = 1'b0;
      chk("ld_accept_busy", busy, 1);
      chk("ld_accept_func", risk_func, 3'b111);
      tick();
      chk("ld_a_func", risk_func, 3'b111); chk("ld_a_addr", risk_addr, 17'h00100);
      chk("ld_a_reg", risk_reg, 1);        chk("ld_a_done", done, 0);
      tick();
      chk("ld_b_func", risk_func, 3'b111); chk("ld_b_addr", risk_addr, 17'h00100);
      chk("ld_b_done", done, 0);
      tick();
      chk("ld_c_func", risk_func, 3'b000); chk("ld_c_addr", risk_addr, 17'h00100);
      chk("ld_c_sx", risk_stride_x, 1);    chk("ld_c_sy", risk_stride_y, 4);
      chk("ld_c_done", done, 1);
      tick();
      chk("ld_end_func", risk_func, 3'b111); chk("ld_end_done", done, 0);
      chk("ld_end_busy", busy, 0);

      // Store reg 0, addr 0x1FFF0, strides 1/128
      drive(2'b01, 5'd0, 17'h1FFF0, 15'd1, 15'd128);
      tick(); cmd_valid = 1'b0;
      tick();
      chk("st_a_func", risk_func, 3'b001); chk("st_a_addr", risk_addr, 17'h1FFF0);
      chk("st_a_done", done, 0);           chk("st_a_sy", risk_stride_y, 128);
      tick();
      chk("st_b_func", risk_func, 3'b111); chk("st_b_addr", risk_addr, 17'h1FFF0);
      chk("st_b_done", done, 1);
      tick();
      chk("st_end_done", done, 0); chk("st_end_busy", busy, 0);

      // Four zeros back-to-back, registers 0,1,2,0
      drive(2'b10, 5'd0, 17'h00010, 15'd0, 15'd0); tick();
      drive(2'b10, 5'd1, 17'h00020, 15'd0, 15'd0); tick();
      chk("z0_func", risk_func, 3'b010); chk("z0_reg", risk_reg, 0); chk("z0_done", done, 1);
      drive(2'b10, 5'd2, 17'h00030, 15'd0, 15'd0); tick();
      chk("z1_func", risk_func, 3'b010); chk("z1_reg", risk_reg, 1); chk("z1_done", done, 1);
      drive(2'b10, 5'd0, 17'h00040, 15'd0, 15'd0); tick();
      cmd_valid = 1'b0;
      chk("z2_func", risk_func, 3'b010); chk("z2_reg", risk_reg, 2); chk("z2_done", done, 1);
      tick();
      chk("z3_func", risk_func, 3'b010); chk("z3_reg", risk_reg, 0); chk("z3_done", done, 1);
      chk("z3_addr", risk_addr, 17'h00040);
      tick();
      chk("z_end_func", risk_func, 3'b111); chk("z_end_done", done, 0); chk("z_end_busy", busy, 0);

      // Six loads with valid held: pushes accepted at cycles 0..5, completions every 3 cycles
      ndone = 0;
      drive(2'b00, 5'd0, 17'h00010, 15'd2, 15'd3);
      for (int c = 0; c < 20; c++) begin
         tick();
         if (c < 5) drive(2'b00, 5'((c + 1) % 3), 17'(17'h00010 + c + 1), 15'd2, 15'd3);
         else cmd_valid = 1'b0;
         ed = (c >= 3 && c <= 18 && c % 3 == 0);
         ef = (c >= 1 && c <= 18 && c % 3 == 0) ? 3'b000 : 3'b111;
         chk($sformatf("b2b_func_c%0d", c), risk_func, ef);
         chk($sformatf("b2b_done_c%0d", c), done, ed);
         chk($sformatf("b2b_ready_c%0d", c), cmd_ready, (c == 5 || c == 6) ? 0 : 1);
         chk($sformatf("b2b_busy_c%0d", c), busy, (c == 19) ? 0 : 1);
         if (ed) begin
            chk($sformatf("b2b_addr_%0d", ndone), risk_addr, 17'h00010 + ndone);
            chk($sformatf("b2b_reg_%0d", ndone), risk_reg, ndone % 3);
            ndone++;
         end
      end
      chk("b2b_count", ndone, 6);

      // Rejected commands then a valid zero
      drive(2'b11, 5'd0, 17'h00000, 15'd0, 15'd0); tick();
      chk("e0_err", err, 0);
      drive(2'b00, 5'd5, 17'h00000, 15'd0, 15'd0); tick();
      chk("e1_err", err, 1); chk("e1_func", risk_func, 3'b111); chk("e1_done", done, 0);
      drive(2'b10, 5'd2, 17'h00777, 15'd0, 15'd0); tick();
      cmd_valid = 1'b0;
      chk("e2_err", err, 1); chk("e2_func", risk_func, 3'b111); chk("e2_done", done, 0);
      tick();
      chk("ez_err", err, 0); chk("ez_func", risk_func, 3'b010); chk("ez_done", done, 1);
      chk("ez_reg", risk_reg, 2); chk("ez_addr", risk_addr, 17'h00777);
      tick();
      chk("ez_end_func", risk_func, 3'b111); chk("ez_end_busy", busy, 0);

      // Three loads, reset during the first LD_B
      drive(2'b00, 5'd2, 17'h0ABCD, 15'd7, 15'd9); tick();
      drive(2'b00, 5'd1, 17'h01111, 15'd7, 15'd9); tick();
      drive(2'b00, 5'd0, 17'h02222, 15'd7, 15'd9); tick();
      cmd_valid = 1'b0;
      chk("pre_rst_addr", risk_addr, 17'h0ABCD);
      chk("pre_rst_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_func", risk_func, 3'b111);
      chk("arst_reg", risk_reg, 0);
      chk("arst_addr", risk_addr, 0);
      chk("arst_sx", risk_stride_x, 0);
      chk("arst_sy", risk_stride_y, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ready", cmd_ready, 1);
      chk("arst_done", done, 0);
      tick();
      #2 reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         chk($sformatf("post_rst_done_c%0d", c), done, 0);
         chk($sformatf("post_rst_func_c%0d", c), risk_func, 3'b111);
         chk($sformatf("post_rst_busy_c%0d", c), busy, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
